fetch_ctrl: RTL and testbench

Fetch-stage controller that owns the program counter and sequences instruction-memory requests into the IF/ID pipeline register. It applies downstream stall and branch/jump redirect from EX, and inserts bubbles on flush. It sits between the instruction memory port and the decode stage, replacing the free-running PC+4 fetch with a handshaked, stall- and flush-aware one.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_hold_buf.sv | 36 +++
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: widths, IF/ID field layout, reset
// constants and the fetch FSM state encoding.
package fetch_pkg;

  localparam int XLEN     = 32;
  localparam int IFID_W   = 64;
  localparam int PC_HI    = 63;
  localparam int PC_LO    = 32;
  localparam int INSTR_HI = 31;
  localparam int INSTR_LO = 0;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef enum logic [1:0] {
    FS_IDLE = ST_IDLE,
    FS_REQ  = ST_REQ,
    FS_HOLD = ST_HOLD,
    FS_DROP = ST_DROP
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [IFID_W-1:0] pack_ifid(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] instr);
    return {pc, instr};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for an IF/ID-style {pc, instr} word.
// Load wins over clear when both are asserted in the same cycle.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int W = IFID_W,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= RESET_VAL;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues handshaked imem requests and
// fills IF/ID, honouring stall, EX redirects and outstanding-request drops.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              ifid_valid,
  output logic [IFID_W-1:0] ifid_bus,
  output fetch_state_e      dbg_state
);

  // Handshake: a request is accepted in any cycle where imem_req and
  // imem_ready are both high; imem_rdata is valid in that same cycle.
  // imem_req/imem_addr are held stable until accepted.

  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pending_pc;
  logic              r_ifid_valid;
  logic [IFID_W-1:0] r_ifid_bus;

  logic [1:0]        w_state_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   w_pending_nxt;
  logic              w_ifid_valid_nxt;
  logic [IFID_W-1:0] w_ifid_bus_nxt;
  logic              w_buf_load;
  logic              w_buf_clear;
  logic [IFID_W-1:0] w_buf_data;
  logic              w_buf_valid;
  logic              w_accept;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_plus4;

  // Request outputs decode only from registered state, never from ready/redirect.
  assign imem_req   = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign imem_addr  = r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_bus   = r_ifid_bus;
  assign dbg_state  = fetch_state_e'(r_state);

  assign w_accept   = imem_req & imem_ready;
  assign w_target   = align_word(redirect_pc);
  assign w_pc_plus4 = r_pc + 32'd4;

  fetch_hold_buf #(
    .W         (IFID_W),
    .RESET_VAL (pack_ifid(RESET_PC, NOP_INSTR))
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (pack_ifid(r_pc, imem_rdata)),
    .o_data  (w_buf_data),
    .o_valid (w_buf_valid)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pending_nxt    = r_pending_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_bus_nxt   = r_ifid_bus;
    w_buf_load       = 1'b0;
    w_buf_clear      = 1'b0;

    if (redirect_valid) begin
      // Flush beats stall; the flushed slot carries the redirect target as pc.
      w_ifid_valid_nxt = 1'b0;
      w_ifid_bus_nxt   = pack_ifid(w_target, NOP_INSTR);
      w_buf_clear      = 1'b1;
      case (r_state)
        ST_REQ, ST_DROP: begin
          if (w_accept) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_REQ;
          end else begin
            w_pending_nxt = w_target;
            w_state_nxt   = ST_DROP;
          end
        end
        default: begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_REQ;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (w_accept && !stall) begin
            w_ifid_valid_nxt = 1'b1;
            w_ifid_bus_nxt   = pack_ifid(r_pc, imem_rdata);
            w_pc_nxt         = w_pc_plus4;
          end else if (w_accept) begin
            w_buf_load  = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ST_HOLD;
          end else if (!stall) begin
            w_ifid_valid_nxt = 1'b0;
            w_ifid_bus_nxt   = pack_ifid(r_pc, NOP_INSTR);
          end
        end
        ST_HOLD: begin
          if (!stall && w_buf_valid) begin
            w_ifid_valid_nxt = 1'b1;
            w_ifid_bus_nxt   = w_buf_data;
            w_buf_clear      = 1'b1;
            w_state_nxt      = ST_REQ;
          end
        end
        ST_DROP: begin
          // The old request's data is discarded; IF/ID stays flushed.
          if (w_accept) begin
            w_pc_nxt    = r_pending_pc;
            w_state_nxt = ST_REQ;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_bus   <= pack_ifid(RESET_PC, NOP_INSTR);
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_bus   <= w_ifid_bus_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each scenario starts from reset and checks
// hand-computed outputs one cycle at a time. Memory returns addr + 0x1000_0000.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              ifid_valid;
  logic [63:0]       ifid_bus;
  fetch_state_e      dbg_state;

  int n_vec;
  int n_err;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h1000_0000;

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_bus       (ifid_bus),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + OFS;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset values
    do_reset();
    chk("rst_req",   {63'd0, imem_req},   64'd0);
    chk("rst_addr",  {32'd0, imem_addr},  64'd0);
    chk("rst_valid", {63'd0, ifid_valid}, 64'd0);
    chk("rst_bus",   ifid_bus,            {32'h0, NOP});
    chk("rst_state", {62'd0, dbg_state},  {62'd0, ST_IDLE});

    // Streaming with ready=1, then 3 ready-low cycles on addr 8
    imem_ready = 1'b1;
    tick();
    chk("s1_req",   {63'd0, imem_req},  64'd1);
    chk("s1_addr0", {32'd0, imem_addr}, 64'h0);
    tick();
    chk("s1_addr4", {32'd0, imem_addr}, 64'h4);
    chk("s1_if0",   {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h0, OFS});
    tick();
    chk("s1_addr8", {32'd0, imem_addr}, 64'h8);
    chk("s1_if4",   {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h4, OFS + 32'h4});
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_hold_addr", {32'd0, imem_addr}, 64'h8);
      chk("s2_bubble",    {31'd0, ifid_valid, ifid_bus[31:0]}, {32'd0, NOP});
    end
    imem_ready = 1'b1;
    tick();
    chk("s2_if8",   {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h8, OFS + 32'h8});
    chk("s2_addrC", {32'd0, imem_addr}, 64'hC);

    // Stall on accept of addr 4 for 2 cycles
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    chk("s3_addr4", {32'd0, imem_addr}, 64'h4);
    stall = 1'b1;
    tick();
    chk("s3_if0_a", {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h0, OFS});
    chk("s3_state", {62'd0, dbg_state}, {62'd0, ST_HOLD});
    chk("s3_noreq", {63'd0, imem_req}, 64'd0);
    tick();
    chk("s3_if0_b", {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h0, OFS});
    stall = 1'b0;
    tick();
    chk("s3_if4",   {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h4, OFS + 32'h4});
    chk("s3_addr8", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h8});
    tick();
    chk("s3_if8",   {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h8, OFS + 32'h8});

    // Redirect + stall + accept in one cycle
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    chk("s4_flush", {ifid_valid, ifid_bus[62:0]}, {1'b0, 31'h100, NOP});
    chk("s4_addr",  {32'd0, imem_addr}, 64'h100);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    chk("s4_if100", {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h100, OFS + 32'h100});
    chk("s4_addr2", {32'd0, imem_addr}, 64'h104);

    // Redirect to 0x203 while addr C is outstanding
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("s5_addrC", {32'd0, imem_addr}, 64'hC);
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    chk("s5_drop",   {62'd0, dbg_state}, {62'd0, ST_DROP});
    chk("s5_keepC",  {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hC});
    chk("s5_flush",  {ifid_valid, ifid_bus[62:0]}, {1'b0, 31'h200, NOP});
    redirect_valid = 1'b0;
    tick();
    chk("s5_keepC2", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hC});
    imem_ready = 1'b1;
    tick();
    chk("s5_addr200", {32'd0, imem_addr}, 64'h200);
    chk("s5_dropped", {ifid_valid, ifid_bus[62:0]}, {1'b0, 31'h200, NOP});
    tick();
    chk("s5_if200", {ifid_valid, ifid_bus[62:0]}, {1'b1, 31'h200, OFS + 32'h200});

    // PC wrap, then asynchronous reset while in DROP
    do_reset();
    imem_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    chk("s6_addrtop", {32'd0, imem_addr}, 64'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    chk("s6_wrap",  {32'd0, imem_addr}, 64'h0);
    chk("s6_iftop", ifid_bus, {32'hFFFF_FFFC, 32'h0FFF_FFFC});
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    chk("s6_drop", {62'd0, dbg_state}, {62'd0, ST_DROP});
    redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_req",   {63'd0, imem_req},   64'd0);
    chk("s6_arst_addr",  {32'd0, imem_addr},  64'd0);
    chk("s6_arst_valid", {63'd0, ifid_valid}, 64'd0);
    chk("s6_arst_bus",   ifid_bus,            {32'h0, NOP});
    chk("s6_arst_state", {62'd0, dbg_state},  {62'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
